// File: rtl/standlight_mode_controller.sv
// Stand light mode sequencer: button-stepped OFF/LOW/MID/HIGH/BLINK FSM driving a PWM/blink lamp and status LEDs.
// Outputs registered, 1-cycle latency; optional inactivity auto-off built only when AUTO_OFF_EN is defined.
module standlight_mode_controller #(
    parameter int PWM_PERIOD      = 100,
    parameter int DUTY_LOW        = 25,
    parameter int DUTY_MID        = 50,
    parameter int DUTY_HIGH       = 100,
    parameter int BLINK_HALF      = 25_000_000
`ifdef AUTO_OFF_EN
    ,
    parameter int AUTO_OFF_CYCLES = 500_000_000
`endif
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_mode_btn,
    input  logic       i_off_btn,
    output logic       o_light,
    output logic [2:0] o_mode,
    output logic [4:0] o_mode_led
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_LOW   = 3'd1,
        S_MID   = 3'd2,
        S_HIGH  = 3'd3,
        S_BLINK = 3'd4
    } state_t;

    localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    state_t          r_state;
    logic [PW-1:0]   r_pwm_cnt;
    logic [BW-1:0]   r_blink_cnt;
    logic            r_blink_ph;
    logic            r_light;
    logic [4:0]      r_mode_led;

    state_t          w_next;
    state_t          w_adv;
    logic            w_valid;
    logic            w_light;
    logic            w_expire;

    always_comb begin
        case (r_state)
            S_OFF:   begin w_valid = 1'b1; w_adv = S_LOW;   end
            S_LOW:   begin w_valid = 1'b1; w_adv = S_MID;   end
            S_MID:   begin w_valid = 1'b1; w_adv = S_HIGH;  end
            S_HIGH:  begin w_valid = 1'b1; w_adv = S_BLINK; end
            S_BLINK: begin w_valid = 1'b1; w_adv = S_OFF;   end
            default: begin w_valid = 1'b0; w_adv = S_OFF;   end
        endcase
    end

    // Off beats mode, and any button pulse beats inactivity expiry.
    always_comb begin
        w_next = w_valid ? r_state : S_OFF;
        if (i_off_btn)
            w_next = S_OFF;
        else if (i_mode_btn)
            w_next = w_adv;
        else if (w_expire)
            w_next = S_OFF;
    end

    always_comb begin
        case (r_state)
            S_LOW:   w_light = int'(r_pwm_cnt) < DUTY_LOW;
            S_MID:   w_light = int'(r_pwm_cnt) < DUTY_MID;
            S_HIGH:  w_light = int'(r_pwm_cnt) < DUTY_HIGH;
            S_BLINK: w_light = r_blink_ph;
            default: w_light = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_OFF;
            r_pwm_cnt   <= '0;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
            r_light     <= 1'b0;
            r_mode_led  <= 5'b00001;
        end else begin
            r_state    <= w_next;
            r_mode_led <= 5'd1 << w_next;
            r_light    <= w_light;

            // A fresh PWM period starts with every mode change.
            if (w_next != r_state || r_pwm_cnt == PW'(PWM_PERIOD - 1))
                r_pwm_cnt <= '0;
            else
                r_pwm_cnt <= r_pwm_cnt + PW'(1);

            if (w_next != S_BLINK) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= 1'b0;
            end else if (r_state != S_BLINK) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= 1'b1;
            end else if (r_blink_cnt == BW'(BLINK_HALF - 1)) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

`ifdef AUTO_OFF_EN
    localparam int AW = (AUTO_OFF_CYCLES > 1) ? $clog2(AUTO_OFF_CYCLES) : 1;

    logic [AW-1:0] r_idle_cnt;

    assign w_expire = (r_state != S_OFF) && (r_idle_cnt == AW'(AUTO_OFF_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_idle_cnt <= '0;
        else if (i_mode_btn || i_off_btn || r_state == S_OFF || w_expire)
            r_idle_cnt <= '0;
        else
            r_idle_cnt <= r_idle_cnt + AW'(1);
    end
`else
    assign w_expire = 1'b0;
`endif

    assign o_mode     = r_state;
    assign o_mode_led = r_mode_led;
    assign o_light    = r_light;

endmodule

// File: tb/tb_standlight_mode_controller.sv
// Scoreboard bench for standlight_mode_controller: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_standlight_mode_controller;

    logic       i_clk;
    logic       i_reset;
    logic       i_mode_btn;
    logic       i_off_btn;
    logic       o_light;
    logic [2:0] o_mode;
    logic [4:0] o_mode_led;

    typedef struct {
        int   cyc;
        int   mode;
        bit   chk_light;
        logic light;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   now   = 0;
    int   base  = 0;

    standlight_mode_controller #(
        .PWM_PERIOD (10),
        .DUTY_LOW   (2),
        .DUTY_MID   (5),
        .DUTY_HIGH  (10),
        .BLINK_HALF (4)
`ifdef AUTO_OFF_EN
        ,
        .AUTO_OFF_CYCLES(50)
`endif
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_mode_btn (i_mode_btn),
        .i_off_btn  (i_off_btn),
        .o_light    (o_light),
        .o_mode     (o_mode),
        .o_mode_led (o_mode_led)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) now <= now + 1;

    task automatic check(input string name, input int em, input logic el, input bit cl);
        logic [2:0] m;
        logic [4:0] led;
        m   = 3'(em);
        led = 5'd1 << m;
        n_vec++;
        if (o_mode !== m || o_mode_led !== led || (cl && o_light !== el)) begin
            n_bad++;
            $display("FAIL %s: got mode=%0d led=%b light=%b, required mode=%0d led=%b light=%b (light checked=%0d)",
                     name, o_mode, o_mode_led, o_light, m, led, el, cl);
        end
    endtask

    // Lamp level k cycles after a mode change, hand-derived from period 10, duties 2/5/10, blink half 4.
    function automatic logic light_exp(input int m, input int k);
        case (m)
            1:       return ((k - 1) % 10) < 2;
            2:       return ((k - 1) % 10) < 5;
            3:       return 1'b1;
            4:       return (((k - 1) / 4) % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge i_clk) begin
        exp_t e;
        if (!i_reset) begin
            while (q.size() > 0 && q[0].cyc < now) begin
                n_vec++;
                n_bad++;
                $display("FAIL missed_cycle: expectation for cycle %0d still queued at cycle %0d, required none",
                         q[0].cyc, now);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == now) begin
                e = q.pop_front();
                check($sformatf("cyc%0d", e.cyc), e.mode, e.light, e.chk_light);
            end
        end
    end

    task automatic press(input int mb, input int ob, input int em);
        @(negedge i_clk);
        i_mode_btn = mb[0];
        i_off_btn  = ob[0];
        @(posedge i_clk);
        #1;
        i_mode_btn = 1'b0;
        i_off_btn  = 1'b0;
        base = now;
        q.push_back('{base, em, 1'b0, 1'b0});
    endtask

    task automatic hold(input int m, input int n);
        for (int k = 1; k <= n; k++)
            q.push_back('{base + k, m, 1'b1, light_exp(m, k)});
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic expire(input int m);
        hold(m, 49);
        q.push_back('{base + 50, 0, 1'b0, 1'b0});
        @(posedge i_clk);
        #1;
        base = now;
    endtask

    initial begin
        i_reset    = 1'b0;
        i_mode_btn = 1'b0;
        i_off_btn  = 1'b0;
        #1 i_reset = 1'b1;
        #2 check("reset_state", 0, 1'b0, 1'b1);
        @(negedge i_clk);
        i_reset = 1'b0;

        // Full mode cycle, 30 cycles per mode, including PWM duty patterns.
        press(1, 0, 1); hold(1, 29);
        press(1, 0, 2); hold(2, 29);
        press(1, 0, 3); hold(3, 29);
        press(1, 0, 4); hold(4, 29);
        press(1, 0, 0); hold(0, 29);

        // Blink pattern, then forced off, then off while already off.
        press(1, 0, 1); hold(1, 1);
        press(1, 0, 2); hold(2, 1);
        press(1, 0, 3); hold(3, 1);
        press(1, 0, 4); hold(4, 12);
        press(0, 1, 0); hold(0, 4);
        press(0, 1, 0); hold(0, 2);

        // Both buttons together in MID.
        press(1, 0, 1); hold(1, 1);
        press(1, 0, 2); hold(2, 3);
        press(1, 1, 0); hold(0, 3);

        // Asynchronous reset while the lamp is on in HIGH.
        press(1, 0, 1); hold(1, 1);
        press(1, 0, 2); hold(2, 1);
        press(1, 0, 3); hold(3, 4);
        @(negedge i_clk);
        #2 i_reset = 1'b1;
        #1 check("async_reset", 0, 1'b0, 1'b1);
        @(negedge i_clk);
        i_reset = 1'b0;
        press(1, 0, 1); hold(1, 12);

`ifdef AUTO_OFF_EN
        press(1, 0, 2); hold(2, 1);
        press(1, 0, 3); expire(3); hold(0, 3);
        press(1, 0, 1); hold(1, 1);
        press(1, 0, 2); hold(2, 1);
        press(1, 0, 3); hold(3, 48);
        press(1, 0, 4); expire(4); hold(0, 3);
`else
        press(1, 0, 2); hold(2, 1);
        press(1, 0, 3); hold(3, 200);
        press(0, 1, 0); hold(0, 2);
`endif

        repeat (3) @(posedge i_clk);
        #1;
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
